// File: rtl/dac_frame_loader.sv
// Multi-channel DAC loader: addressed serial frames into holding registers,
// transferred to the active DAC outputs on ldac or automatically.
module dac_frame_loader #(
  parameter int WIDTH = 10,
  parameter int NUM_CH = 4,
  parameter bit AUTO_UPDATE = 1'b0,
  parameter logic [WIDTH-1:0] RESET_CODE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs_n,
  input  logic                    bit_valid,
  input  logic                    bit_in,
  input  logic                    ldac,
  output logic [NUM_CH*WIDTH-1:0] dac_out,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FRAME_LEN = ADDR_W + WIDTH;
  localparam int CNT_W = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] sr;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     hold [NUM_CH];
  logic [WIDTH-1:0]     act  [NUM_CH];

  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  code;
  logic              commit_ok;
  logic [NUM_CH-1:0] hit;

  assign addr = sr[FRAME_LEN-1 -: ADDR_W];
  assign code = sr[WIDTH-1:0];
  assign commit_ok = (state == COMMIT)
                  && (cnt == CNT_FULL)
                  && ({1'b0, addr} < (ADDR_W+1)'(NUM_CH));

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hit[k] = commit_ok && (addr == ADDR_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!cs_n) begin
            state <= SHIFT;
            busy  <= 1'b1;
            if (bit_valid) begin
              sr  <= {sr[FRAME_LEN-2:0], bit_in};
              cnt <= CNT_W'(1);
            end
          end
        end
        SHIFT: begin
          if (cs_n) begin
            state <= COMMIT;
          end else if (bit_valid) begin
            sr <= {sr[FRAME_LEN-2:0], bit_in};
            if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          // one-cycle verdict; a low cs_n here is not a new frame yet
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= commit_ok;
          frame_err  <= !commit_ok;
          sr         <= '0;
          cnt        <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        hold[k] <= RESET_CODE;
        act[k]  <= RESET_CODE;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (hit[k]) hold[k] <= code;
        // fresh code bypasses the holding register on a same-cycle ldac
        if (ldac || (AUTO_UPDATE && hit[k])) begin
          act[k] <= hit[k] ? code : hold[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign dac_out[k*WIDTH +: WIDTH] = act[k];
  end

endmodule

// File: tb/tb_dac_frame_loader.sv
// Scoreboard bench for dac_frame_loader: default, 3-channel
// and auto-update instances driven independently.
module tb_dac_frame_loader;

  logic       clk = 1'b0;
  logic [2:0] rst_n = '0;
  logic [2:0] cs_n = '1;
  logic [2:0] bv = '0;
  logic [2:0] bi = '0;
  logic [2:0] ldac = '0;
  logic [2:0] done;
  logic [2:0] err;
  logic [2:0] busy;
  logic [39:0] dac0;
  logic [29:0] dac1;
  logic [39:0] dac2;

  int n_cmp = 0;
  int n_bad = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  localparam int K_DONE = 1;
  localparam int K_ERR = 2;

  always #5 clk = ~clk;

  dac_frame_loader u_def (
    .clk(clk), .rst_n(rst_n[0]), .cs_n(cs_n[0]),
    .bit_valid(bv[0]), .bit_in(bi[0]), .ldac(ldac[0]),
    .dac_out(dac0), .frame_done(done[0]),
    .frame_err(err[0]), .busy(busy[0])
  );

  dac_frame_loader #(.NUM_CH(3)) u_ch3 (
    .clk(clk), .rst_n(rst_n[1]), .cs_n(cs_n[1]),
    .bit_valid(bv[1]), .bit_in(bi[1]), .ldac(ldac[1]),
    .dac_out(dac1), .frame_done(done[1]),
    .frame_err(err[1]), .busy(busy[1])
  );

  dac_frame_loader #(.AUTO_UPDATE(1'b1)) u_auto (
    .clk(clk), .rst_n(rst_n[2]), .cs_n(cs_n[2]),
    .bit_valid(bv[2]), .bit_in(bi[2]), .ldac(ldac[2]),
    .dac_out(dac2), .frame_done(done[2]),
    .frame_err(err[2]), .busy(busy[2])
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input int i, input int kind);
    case (i)
      0: q0.push_back(kind);
      1: q1.push_back(kind);
      default: q2.push_back(kind);
    endcase
  endtask

  task automatic sb_pop(input int i, input int kind);
    int exp;
    exp = -1;
    case (i)
      0: if (q0.size() > 0) exp = q0.pop_front();
      1: if (q1.size() > 0) exp = q1.pop_front();
      default: if (q2.size() > 0) exp = q2.pop_front();
    endcase
    if (exp < 0) chk($sformatf("unexpected_pulse_u%0d", i), kind, 0);
    else chk($sformatf("pulse_u%0d", i), kind, exp);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n[i] && (done[i] || err[i])) begin
        sb_pop(i, {err[i], done[i]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input int n,
                      input logic [31:0] w,
                      input bit ld_commit, input int kind);
    @(posedge clk); #1;
    cs_n[i] = 1'b0;
    bv[i] = 1'b1;
    bi[i] = w[n-1];
    for (int j = n - 2; j >= 0; j--) begin
      @(posedge clk); #1;
      bi[i] = w[j];
      if (j == n - 2) chk($sformatf("busy_mid_u%0d", i), busy[i], 1);
    end
    @(posedge clk); #1;
    cs_n[i] = 1'b1;
    bv[i] = 1'b0;
    sb_push(i, kind);
    @(posedge clk); #1;
    if (ld_commit) ldac[i] = 1'b1;
    @(posedge clk); #1;
    ldac[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_ldac(input int i);
    @(posedge clk); #1;
    ldac[i] = 1'b1;
    @(posedge clk); #1;
    ldac[i] = 1'b0;
  endtask

  initial begin
    tick(3);
    rst_n = '1;
    tick(2);
    chk("rst_dac0", dac0, 0);
    chk("rst_dac1", dac1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, err}, 0);

    send(0, 12, {2'b10, 10'h2A5}, 1'b0, K_DONE);
    chk("no_ldac_hold", dac0, 0);
    pulse_ldac(0);
    chk("ldac_ch2", dac0, 40'h2A5 << 20);

    send(0, 11, 32'h5A5, 1'b0, K_ERR);
    send(0, 13, 32'h1ABC, 1'b0, K_ERR);
    chk("bad_len_out", dac0, 40'h2A5 << 20);
    pulse_ldac(0);
    chk("bad_len_ldac", dac0, 40'h2A5 << 20);

    send(0, 12, {2'b00, 10'h0F0}, 1'b0, K_DONE);
    chk("ch0_not_live", dac0, 40'h2A5 << 20);
    send(0, 12, {2'b01, 10'h155}, 1'b1, K_DONE);
    chk("ldac_bypass", dac0,
        (40'h2A5 << 20) | (40'h155 << 10) | 40'h0F0);

    send(1, 12, {2'b11, 10'h3FF}, 1'b0, K_ERR);
    pulse_ldac(1);
    chk("bad_addr", dac1, 0);
    send(1, 12, {2'b10, 10'h123}, 1'b0, K_DONE);
    pulse_ldac(1);
    chk("ch3_top", dac1, 30'h123 << 20);

    send(2, 12, {2'b11, 10'h201}, 1'b0, K_DONE);
    chk("auto_ch3", dac2, 40'h201 << 30);

    @(posedge clk); #1;
    cs_n[2] = 1'b0;
    bv[2] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      bi[2] = j[0];
      @(posedge clk); #1;
    end
    rst_n[2] = 1'b0;
    #1;
    chk("midrst_dac", dac2, 0);
    chk("midrst_busy", busy[2], 0);
    cs_n[2] = 1'b1;
    bv[2] = 1'b0;
    tick(2);
    rst_n[2] = 1'b1;
    tick(2);
    send(2, 12, {2'b01, 10'h0AB}, 1'b0, K_DONE);
    chk("post_rst_auto", dac2, 40'h0AB << 10);

    tick(4);
    chk("sb_drain_u0", q0.size(), 0);
    chk("sb_drain_u1", q1.size(), 0);
    chk("sb_drain_u2", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
